// File: rtl/video_timing_recover.sv
// Rebuilds pixel coordinates, new-frame pulse and frame counter from a raw hs/vs/ad
// stream, and qualifies every frame against the expected timing to report lock and errors.
module video_timing_recover #(
    parameter int unsigned ACTIVE_H_PIXELS = 1280,
    parameter int unsigned H_FRONT_PORCH   = 110,
    parameter int unsigned H_SYNC_WIDTH    = 40,
    parameter int unsigned H_BACK_PORCH    = 220,
    parameter int unsigned ACTIVE_LINES    = 720,
    parameter int unsigned V_FRONT_PORCH   = 5,
    parameter int unsigned V_SYNC_WIDTH    = 5,
    parameter int unsigned V_BACK_PORCH    = 20,
    parameter int unsigned LOCK_FRAMES     = 2,
    localparam int unsigned TOTAL_PIXELS   = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
    localparam int unsigned TOTAL_LINES    = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
    localparam int unsigned HW             = $clog2(TOTAL_PIXELS),
    localparam int unsigned VW             = $clog2(TOTAL_LINES)
) (
    input  logic          clk_pixel_in,
    input  logic          rst_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          ad_in,
    output logic [HW-1:0] hcount_out,
    output logic [VW-1:0] vcount_out,
    output logic          ad_out,
    output logic          nf_out,
    output logic [5:0]    fc_out,
    output logic          locked_out,
    output logic          err_out
);

    // Measurement counters get headroom above the nominal totals so a long line/frame
    // can never saturate onto the expected value.
    localparam int unsigned PW = $clog2(TOTAL_PIXELS + 2);
    localparam int unsigned LW = $clog2(TOTAL_LINES + 2);
    localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic          hs_q;
    logic          vs_q;
    logic          ad_q;
    logic          hs_rise;
    logic          vs_rise;
    logic          vs_fall;
    logic          ad_rise;
    logic          ad_fall;

    logic          first_line;
    logic [PW-1:0] pix_cnt;
    logic [PW-1:0] act_cnt;
    logic [LW-1:0] line_cnt;
    logic [LW-1:0] aline_cnt;
    logic          first_hs_done;
    logic          line_bad;
    logic          frame_good;

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] good_cnt;
    logic [GW-1:0] good_cnt_nxt;
    logic          err_nxt;

    // Input stage
    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            ad_q <= 1'b0;
        end else begin
            hs_q <= hs_in;
            vs_q <= vs_in;
            ad_q <= ad_in;
        end
    end

    assign hs_rise = hs_in & ~hs_q;
    assign vs_rise = vs_in & ~vs_q;
    assign vs_fall = ~vs_in & vs_q;
    assign ad_rise = ad_in & ~ad_q;
    assign ad_fall = ~ad_in & ad_q;
    assign ad_out  = ad_q;

    // Recovered coordinates; vcount restarts on the first active line after vsync
    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            hcount_out <= '0;
            vcount_out <= '0;
            first_line <= 1'b0;
        end else begin
            if (ad_rise) begin
                hcount_out <= '0;
                if (first_line) begin
                    vcount_out <= '0;
                end else if (vcount_out != '1) begin
                    vcount_out <= vcount_out + VW'(1);
                end
            end else if (ad_in && (hcount_out != '1)) begin
                hcount_out <= hcount_out + HW'(1);
            end

            if (vs_fall) begin
                first_line <= 1'b1;
            end else if (ad_rise) begin
                first_line <= 1'b0;
            end
        end
    end

    // Frame pulse and frame counter
    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            nf_out <= 1'b0;
            fc_out <= '0;
        end else begin
            nf_out <= vs_rise;
            if (vs_rise) begin
                fc_out <= fc_out + 6'd1;
            end
        end
    end

    // Line/frame measurement; an hs rise coincident with vs rise opens line 1 of the new frame
    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            pix_cnt       <= '0;
            act_cnt       <= '0;
            line_cnt      <= '0;
            aline_cnt     <= '0;
            first_hs_done <= 1'b0;
            line_bad      <= 1'b0;
        end else if (vs_rise) begin
            pix_cnt       <= hs_rise ? PW'(1) : '0;
            line_cnt      <= hs_rise ? LW'(1) : '0;
            first_hs_done <= hs_rise;
            act_cnt       <= ad_rise ? PW'(1) : '0;
            aline_cnt     <= ad_rise ? LW'(1) : '0;
            line_bad      <= 1'b0;
        end else begin
            if (hs_rise) begin
                pix_cnt       <= PW'(1);
                first_hs_done <= 1'b1;
                if (line_cnt != '1) begin
                    line_cnt <= line_cnt + LW'(1);
                end
            end else if (pix_cnt != '1) begin
                pix_cnt <= pix_cnt + PW'(1);
            end

            if (ad_rise) begin
                act_cnt <= PW'(1);
                if (aline_cnt != '1) begin
                    aline_cnt <= aline_cnt + LW'(1);
                end
            end else if (ad_in && (act_cnt != '1)) begin
                act_cnt <= act_cnt + PW'(1);
            end

            if ((hs_rise && first_hs_done && (pix_cnt != PW'(TOTAL_PIXELS))) ||
                (ad_fall && (act_cnt != PW'(ACTIVE_H_PIXELS)))) begin
                line_bad <= 1'b1;
            end
        end
    end

    assign frame_good = !line_bad &&
                        (line_cnt == LW'(TOTAL_LINES)) &&
                        (aline_cnt == LW'(ACTIVE_LINES));

    // Lock FSM state register
    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= ST_SEARCH;
            good_cnt   <= '0;
            locked_out <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            state      <= state_nxt;
            good_cnt   <= good_cnt_nxt;
            locked_out <= (state_nxt == ST_LOCKED);
            err_out    <= err_nxt;
        end
    end

    // Lock FSM next state; frames are only judged at vs rise
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        err_nxt      = 1'b0;
        if (vs_rise) begin
            case (state)
                ST_SEARCH: begin
                    state_nxt    = ST_ACQUIRE;
                    good_cnt_nxt = '0;
                end
                ST_ACQUIRE: begin
                    if (!frame_good) begin
                        good_cnt_nxt = '0;
                    end else if (good_cnt >= GW'(LOCK_FRAMES - 1)) begin
                        good_cnt_nxt = GW'(LOCK_FRAMES);
                        state_nxt    = ST_LOCKED;
                    end else begin
                        good_cnt_nxt = good_cnt + GW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good) begin
                        err_nxt      = 1'b1;
                        good_cnt_nxt = '0;
                        state_nxt    = ST_SEARCH;
                    end
                end
                default: begin
                    state_nxt    = ST_SEARCH;
                    good_cnt_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/video_timing_recover.md
# video_timing_recover

Sink-side counterpart to the video timing generator. It takes a raw hsync/vsync/active-draw stream (from the generator or an upstream receiver) and rebuilds the pixel coordinates, new-frame pulse and frame counter from it. It also checks every frame against the expected timing and reports lock and timing errors. Downstream pixel pipelines use it when only sync signals travel with the pixel data.

## Interface
- ACTIVE_H_PIXELS, 1280, expected active pixels per line
- H_FRONT_PORCH, 110; H_SYNC_WIDTH, 40; H_BACK_PORCH, 220, horizontal blanking segments
- ACTIVE_LINES, 720, expected active lines per frame
- V_FRONT_PORCH, 5; V_SYNC_WIDTH, 5; V_BACK_PORCH, 20, vertical blanking segments
- LOCK_FRAMES, 2, consecutive good frames needed to assert lock
- Derived: TOTAL_PIXELS = sum of horizontal params; TOTAL_LINES = sum of vertical params; HW = $clog2(TOTAL_PIXELS); VW = $clog2(TOTAL_LINES)

Ports:
- clk_pixel_in  in  1  pixel clock; the only clock
- rst_in  in  1  reset, asynchronous, active-high
- hs_in  in  1  horizontal sync, active-high
- vs_in  in  1  vertical sync, active-high
- ad_in  in  1  active draw
- hcount_out  out  HW  recovered pixel index within the active line
- vcount_out  out  VW  recovered active line index
- ad_out  out  1  ad_in delayed one cycle, aligned with the counts
- nf_out  out  1  one-cycle new-frame pulse
- fc_out  out  6  frame counter, wraps 63→0
- locked_out  out  1  timing matches the parameters
- err_out  out  1  one-cycle pulse when a locked frame fails its check

## Operation
- Input stage: hs_in, vs_in and ad_in are registered once, into hs_q, vs_q and ad_q.
- Edges are computed from the raw input and its registered copy:
  - rise = in & ~q
  - fall = ~in & q
- Coordinates:
  - ad rise: hcount_out←0. Otherwise, while ad_in=1, hcount_out increments, saturating at all-ones.
  - ad rise with first_line set: vcount_out←0 and first_line is cleared. ad rise with first_line clear: vcount_out increments, saturating.
  - vs fall sets first_line.
  - Outside active draw, hcount_out and vcount_out hold.
- Frame events:
  - vs rise pulses nf_out on the next cycle and increments fc_out.
  - fc_out counts in every lock state.
- Measurement counters, all saturating and cleared at each vs rise:
  - pix_cnt: cycles since the last hs rise.
  - act_cnt: ad_in=1 cycles in the current line.
  - line_cnt: hs rises in the frame.
  - aline_cnt: ad rises in the frame.
- Per-line checks:
  - On each hs rise, except the first one after the frame start, line_bad is set if pix_cnt ≠ TOTAL_PIXELS.
  - On each ad fall, line_bad is set if act_cnt ≠ ACTIVE_H_PIXELS.
  - line_bad is sticky and cleared at vs rise.
- Frame check, evaluated at vs rise for the frame just ended. frame_good requires:
  - !line_bad
  - line_cnt == TOTAL_LINES
  - aline_cnt == ACTIVE_LINES
- Lock FSM:
  - SEARCH: wait for vs rise, then go to ACQUIRE with good_cnt←0. The partial frame seen after reset is never judged.
  - ACQUIRE: at vs rise, frame_good increments good_cnt; a bad frame resets it to 0. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked_out=1. At vs rise, a bad frame pulses err_out for one cycle and returns the FSM to SEARCH.
  - Any vs fall with no intervening vs rise is not possible. Any glitch is caught by the line and frame counts.
- Simultaneous events:
  - vs rise and hs rise in the same cycle: frame evaluation uses the pre-increment counts, then the counters clear. The hs rise is counted as line 1 of the new frame.
  - ad rise and ad fall cannot coincide. A one-cycle ad pulse gives act_cnt=1 and flags the line bad.

## Timing
- Reset, asynchronous: every output is 0, FSM=SEARCH, all counters and flags are 0, first_line=0.
- Release of reset is synchronous to clk_pixel_in.
- Output latency:
  - hcount_out, vcount_out and ad_out lag ad_in by 1 cycle.
  - nf_out is high on the cycle after the vs rise is sampled.
  - locked_out and err_out update on that same cycle.
- Reset asserted mid-frame: everything clears immediately. Lock needs one partial frame plus LOCK_FRAMES full frames to return.
- Counters saturate rather than wrap, so a missing sync can never alias to a good count.

## Test plan
- Small params: ACTIVE_H_PIXELS=16, porches 2/3/4 (TOTAL_PIXELS=25), ACTIVE_LINES=8, vertical 1/2/2 (TOTAL_LINES=13), LOCK_FRAMES=2. Feed a clean stream starting mid-frame → locked_out rises at the 3rd vs rise. err_out stays 0 for 5 frames.
- Clean stream → on every active pixel, hcount_out runs 0..15 and vcount_out runs 0..7, lagging ad_in by one cycle. nf_out pulses once per frame. fc_out wraps 63→0 after 64 frames.
- While locked, stretch one line to 26 cycles → err_out pulses at the next vs rise, locked_out goes 0, and lock returns 3 vs rises later.
- While locked, send 15 active pixels on one line → err_out pulses at frame end. hcount_out peaks at 14 on that line.
- Drop one active line (7 ad rises) → frame is judged bad. In ACQUIRE, good_cnt resets to 0 and locked_out stays 0.
- Assert rst_in asynchronously mid-line → all outputs are 0 before the next clock edge. After release, locked_out=0 until the 3rd vs rise.
